// File: rtl/servo_pkg.sv
// Shared constants and types for the servo PWM blocks (12 MHz tick base).
package servo_pkg;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_SHORT = 2'b01;
  localparam logic [1:0] ERR_LONG  = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  localparam logic [14:0] TICKS_1MS   = 15'd12000;
  localparam logic [19:0] FRAME_TICKS = 20'h3a980;

  localparam logic [14:0] DEF_MIN_ON  = 15'd6000;
  localparam logic [14:0] DEF_MAX_ON  = 15'd30000;
  localparam logic [19:0] DEF_TIMEOUT = 20'h75300;

  typedef enum logic [1:0] {
    ST_ARM      = 2'd0,
    ST_LOW      = 2'd1,
    ST_HIGH     = 2'd2,
    ST_WAIT_LOW = 2'd3
  } cap_state_e;

  function automatic logic pulse_ok(input logic [14:0] cnt,
                                    input logic [14:0] lo,
                                    input logic [14:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage

// File: rtl/servo_in_filt.sv
// Pin synchronizer plus run-length glitch filter with registered level and edge strobes.
module servo_in_filt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic lvl,
  output logic rise,
  output logic fall
);

  localparam logic [3:0] FILT_LEN_C = 4'(FILT_LEN);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [3:0]             run_r;
  logic                   lvl_r;
  logic                   lvl_o_r;
  logic                   rise_r;
  logic                   fall_r;
  logic                   smp_s;
  logic [3:0]             run_inc_s;

  assign smp_s     = sync_r[SYNC_STAGES-1];
  assign run_inc_s = run_r + 4'd1;

  // Synchronize, filter, and register level/edges so all three stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r  <= '1;
      run_r   <= 4'd0;
      lvl_r   <= 1'b1;
      lvl_o_r <= 1'b1;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pin};
      if (smp_s != lvl_r) begin
        if (run_inc_s == FILT_LEN_C) begin
          lvl_r <= smp_s;
          run_r <= 4'd0;
        end else begin
          run_r <= run_inc_s;
        end
      end else begin
        run_r <= 4'd0;
      end
      lvl_o_r <= lvl_r;
      rise_r  <= lvl_r & ~lvl_o_r;
      fall_r  <= ~lvl_r & lvl_o_r;
    end
  end

  assign lvl  = lvl_o_r;
  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/servo_cap.sv
// Servo PWM capture: measures filtered high time, flags short/long pulses and signal loss.
module servo_cap
  import servo_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter int          FILT_LEN    = 3,
  parameter logic [14:0] MIN_ON      = DEF_MIN_ON,
  parameter logic [14:0] MAX_ON      = DEF_MAX_ON,
  parameter logic [19:0] TIMEOUT     = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        srv_i,
  output logic [14:0] on_t,
  output logic        vld,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        sig_ok
);

  logic        lvl_s, rise_s, fall_s;
  cap_state_e  state_r, state_s;
  logic [14:0] hi_cnt_r, hi_cnt_s;
  logic [19:0] tmo_r, tmo_s;
  logic [14:0] on_t_r, on_t_s;
  logic        vld_r, err_r, err_s, sig_ok_r, sig_ok_s;
  logic [1:0]  code_r, code_s;
  logic        good_s, short_s, long_s, tmo_hit_s;

  servo_in_filt #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (srv_i),
    .lvl   (lvl_s),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  // Next-state, width counting and pulse classification.
  always_comb begin
    state_s  = state_r;
    hi_cnt_s = hi_cnt_r;
    good_s   = 1'b0;
    short_s  = 1'b0;
    long_s   = 1'b0;
    case (state_r)
      ST_ARM: begin
        if (!lvl_s) state_s = ST_LOW;
        else        state_s = ST_ARM;
      end
      ST_LOW: begin
        if (rise_s) begin
          hi_cnt_s = 15'd1;
          state_s  = ST_HIGH;
        end else begin
          state_s = ST_LOW;
        end
      end
      ST_HIGH: begin
        if (fall_s) begin
          state_s = ST_LOW;
          if (pulse_ok(hi_cnt_r, MIN_ON, MAX_ON)) good_s  = 1'b1;
          else                                    short_s = 1'b1;
        end else if (lvl_s) begin
          // Saturate instead of wrapping: the overlong pulse is reported once.
          if (hi_cnt_r >= MAX_ON) begin
            long_s  = 1'b1;
            state_s = ST_WAIT_LOW;
          end else begin
            hi_cnt_s = hi_cnt_r + 15'd1;
          end
        end else begin
          state_s = ST_HIGH;
        end
      end
      ST_WAIT_LOW: begin
        if (fall_s) state_s = ST_LOW;
        else        state_s = ST_WAIT_LOW;
      end
      default: state_s = ST_ARM;
    endcase
  end

  // Timeout counter and output register next values; valid pulse beats timeout.
  always_comb begin
    tmo_hit_s = (tmo_r == (TIMEOUT - 20'd1)) && !good_s;
    if (good_s) begin
      tmo_s = 20'd0;
    end else if (tmo_r != TIMEOUT) begin
      tmo_s = tmo_r + 20'd1;
    end else begin
      tmo_s = tmo_r;
    end

    if (good_s) on_t_s = hi_cnt_r;
    else        on_t_s = on_t_r;

    err_s = short_s | long_s | tmo_hit_s;
    if (tmo_hit_s)    code_s = ERR_TMO;
    else if (long_s)  code_s = ERR_LONG;
    else if (short_s) code_s = ERR_SHORT;
    else              code_s = ERR_NONE;

    if (good_s)         sig_ok_s = 1'b1;
    else if (tmo_hit_s) sig_ok_s = 1'b0;
    else                sig_ok_s = sig_ok_r;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_ARM;
      hi_cnt_r <= 15'd0;
      tmo_r    <= 20'd0;
      on_t_r   <= 15'd0;
      vld_r    <= 1'b0;
      err_r    <= 1'b0;
      code_r   <= ERR_NONE;
      sig_ok_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      hi_cnt_r <= hi_cnt_s;
      tmo_r    <= tmo_s;
      on_t_r   <= on_t_s;
      vld_r    <= good_s;
      err_r    <= err_s;
      code_r   <= code_s;
      sig_ok_r <= sig_ok_s;
    end
  end

  assign on_t     = on_t_r;
  assign vld      = vld_r;
  assign err      = err_r;
  assign err_code = code_r;
  assign sig_ok   = sig_ok_r;

endmodule

// File: tb/tb_servo_cap.sv
// Directed bench for servo_cap with tick constants scaled down by 100 for short runtime.
module tb_servo_cap;

  localparam int          SYNC = 2;
  localparam int          FILT = 3;
  localparam logic [14:0] MINV = 15'd60;
  localparam logic [14:0] MAXV = 15'd300;
  localparam logic [19:0] TMOV = 20'd4800;
  localparam int          LAT  = SYNC + FILT + 1;

  logic        clk;
  logic        rst_n;
  logic        srv_i;
  logic [14:0] on_t;
  logic        vld;
  logic        err;
  logic [1:0]  err_code;
  logic        sig_ok;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int vld_n = 0, err_n = 0, code_leak = 0;
  int vld_cyc = 0, err_cyc = 0;
  logic [14:0] last_on = 15'd0;
  logic [1:0]  last_code = 2'b00;
  int rise_cyc = 0, fall_cyc = 0;

  servo_cap #(
    .SYNC_STAGES (SYNC),
    .FILT_LEN    (FILT),
    .MIN_ON      (MINV),
    .MAX_ON      (MAXV),
    .TIMEOUT     (TMOV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .srv_i    (srv_i),
    .on_t     (on_t),
    .vld      (vld),
    .err      (err),
    .err_code (err_code),
    .sig_ok   (sig_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    cyc <= cyc + 1;
    if (vld === 1'b1) begin
      vld_n   <= vld_n + 1;
      vld_cyc <= cyc + 1;
      last_on <= on_t;
    end
    if (err === 1'b1) begin
      err_n     <= err_n + 1;
      err_cyc   <= cyc + 1;
      last_code <= err_code;
    end else if (err_code !== 2'b00) begin
      code_leak <= code_leak + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    @(negedge clk);
    srv_i    = 1'b1;
    rise_cyc = cyc;
    repeat (hi) @(negedge clk);
    srv_i    = 1'b0;
    fall_cyc = cyc;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    int v0, e0, vref;
    int loop_v[3];
    loop_v[0] = 60;
    loop_v[1] = 120;
    loop_v[2] = 240;

    rst_n = 1'b0;
    srv_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_on_t", on_t, 0);
    chk("rst_vld", vld, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_sig_ok", sig_ok, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // clean 180-tick pulses, two frames
    pulse(180, 400);
    chk("clean_on_t", last_on, 180);
    chk("clean_vld_n", vld_n, 1);
    chk("clean_latency", vld_cyc - fall_cyc, LAT + 1);
    chk("clean_sig_ok", sig_ok, 1);
    chk("clean_err_n", err_n, 0);
    pulse(180, 400);
    chk("frame2_vld_n", vld_n, 2);
    chk("frame2_on_t", on_t, 180);

    // short pulse
    pulse(40, 300);
    chk("short_err_n", err_n, 1);
    chk("short_code", last_code, 1);
    chk("short_on_t_kept", on_t, 180);
    chk("short_no_vld", vld_n, 2);

    // exactly MAX accepted
    pulse(300, 300);
    chk("max_on_t", on_t, 300);
    chk("max_vld_n", vld_n, 3);

    // MAX+1 rejected at tick MAX+1, no vld at fall
    pulse(301, 300);
    chk("long_err_n", err_n, 2);
    chk("long_code", last_code, 2);
    chk("long_err_time", err_cyc - rise_cyc, 301 + LAT);
    chk("long_no_vld", vld_n, 3);
    chk("long_on_t_kept", on_t, 300);

    // 120-tick pulse with 2-cycle glitches mid-high and mid-low
    @(negedge clk);
    srv_i = 1'b1;
    repeat (50) @(negedge clk);
    srv_i = 1'b0;
    repeat (2) @(negedge clk);
    srv_i = 1'b1;
    repeat (68) @(negedge clk);
    srv_i = 1'b0;
    repeat (50) @(negedge clk);
    srv_i = 1'b1;
    repeat (2) @(negedge clk);
    srv_i = 1'b0;
    repeat (100) @(negedge clk);
    chk("glitch_on_t", on_t, 120);
    chk("glitch_vld_n", vld_n, 4);
    chk("glitch_err_n", err_n, 2);

    // loss of signal
    vref = vld_cyc;
    repeat (9700) @(negedge clk);
    chk("tmo_err_n", err_n, 3);
    chk("tmo_code", last_code, 3);
    chk("tmo_time", err_cyc - vref, int'(TMOV));
    chk("tmo_sig_ok", sig_ok, 0);
    pulse(240, 400);
    chk("recover_on_t", on_t, 240);
    chk("recover_sig_ok", sig_ok, 1);
    chk("recover_err_n", err_n, 3);

    // reset in the middle of a high pulse
    @(negedge clk);
    srv_i = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("mrst_on_t", on_t, 0);
    chk("mrst_vld", vld, 0);
    chk("mrst_err", err, 0);
    chk("mrst_code", err_code, 0);
    chk("mrst_sig_ok", sig_ok, 0);
    rst_n = 1'b1;
    v0 = vld_n;
    e0 = err_n;
    repeat (100) @(negedge clk);
    srv_i = 1'b0;
    repeat (300) @(negedge clk);
    chk("mrst_tail_vld", vld_n, v0);
    chk("mrst_tail_err", err_n, e0);
    pulse(120, 400);
    chk("mrst_next_on_t", on_t, 120);
    chk("mrst_next_vld", vld_n, v0 + 1);
    chk("mrst_next_sig_ok", sig_ok, 1);

    // servo_drv style loopback frames
    for (int i = 0; i < 3; i++) begin
      v0 = vld_n;
      pulse(loop_v[i], 2400 - loop_v[i]);
      chk("loop_on_t", on_t, loop_v[i]);
      chk("loop_vld_n", vld_n, v0 + 1);
    end
    chk("loop_err_n", err_n, e0);

    // one tick below MIN
    pulse(59, 300);
    chk("below_min_err_n", err_n, e0 + 1);
    chk("below_min_code", last_code, 1);
    chk("below_min_on_t", on_t, 240);

    chk("code_only_with_err", code_leak, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/servo_cap.md
Name: servo_cap

Overview:
- Captures RC/servo PWM pulses on a single input pin and measures each high time in clock ticks.
- Produces the same 15-bit `on_t` encoding that `servo_drv` consumes, at a 12 MHz clock (1 ms = 12000 ticks, 20 ms frame = 240000 ticks).
- Sits between an external receiver pin and control logic, or loops back from `servo_drv` for self-test.
- Flags malformed pulses and loss of signal.

Parameters:
- SYNC_STAGES, 2, synchronizer flop count on `srv_i` (min 2)
- FILT_LEN, 3, consecutive equal samples needed to change the filtered level (1..15)
- MIN_ON, 15'd6000, shortest accepted high time in ticks (0.5 ms)
- MAX_ON, 15'd30000, longest accepted high time in ticks (2.5 ms)
- TIMEOUT, 20'h75300, ticks without a valid pulse before loss of signal is declared (40 ms)

Ports:
- clk  in  1  system clock, 12 MHz
- rst_n  in  1  asynchronous active-low reset
- srv_i  in  1  asynchronous servo PWM input
- on_t  out  15  last valid high time in ticks
- vld  out  1  one-cycle strobe: `on_t` updated this cycle
- err  out  1  one-cycle strobe: error detected
- err_code  out  2  01 short, 10 long, 11 timeout; valid only while `err` is high, else 00
- sig_ok  out  1  high while valid pulses are arriving

Behaviour:
- Reset (asynchronous on `rst_n` low):
  - `on_t`=0, `vld`=0, `err`=0, `err_code`=00, `sig_ok`=0.
  - Synchronizer flops and filtered level reset to 1. Filter run counter cleared.
  - Timeout counter = 0. FSM = ARM.
- Input conditioning:
  - `srv_i` passes through SYNC_STAGES flops.
  - The filtered level `lvl` toggles only after FILT_LEN consecutive synchronized samples differ from it.
  - Rising and falling edges are therefore delayed identically, so a clean pulse of N ticks gives `lvl` high for exactly N cycles.
- rise/fall are single-cycle detections of `lvl` transitions.
- FSM states:
  - ARM: wait for `lvl`=0, then go to LOW. This discards a pulse in progress at reset.
  - LOW: on rise, hi_cnt := 1 and go to HIGH.
  - HIGH: each cycle with `lvl`=1, hi_cnt := hi_cnt+1.
    - On fall with MIN_ON ≤ hi_cnt ≤ MAX_ON: `on_t` := hi_cnt, `vld`=1 for one cycle, `sig_ok` := 1, timeout counter := 0. Go to LOW.
    - On fall with hi_cnt < MIN_ON: `err`=1, code 01, `on_t` unchanged. Go to LOW.
    - If hi_cnt would exceed MAX_ON: `err`=1 with code 10 once, at the cycle hi_cnt = MAX_ON+1. Go to WAIT_LOW; hi_cnt never wraps.
  - WAIT_LOW: on fall, go to LOW with no output activity.
- Latency: `vld` asserts SYNC_STAGES+FILT_LEN+1 cycles after the first clk edge at which `srv_i` is sampled low.
- Timeout:
  - A 20-bit counter increments every cycle and saturates at TIMEOUT.
  - On the cycle it reaches TIMEOUT: `err`=1 with code 11 (once), `sig_ok` := 0.
  - It stays saturated with no further timeout errors until the next valid pulse clears it.
  - The FSM keeps running during timeout.
- Simultaneous events:
  - A valid fall and a timeout in the same cycle: the valid pulse wins, the counter clears, and no timeout error is raised.
  - A short/long error and a timeout in the same cycle: the timeout code wins, and one `err` strobe is issued.
- Reset mid-pulse: the partial pulse is discarded via ARM/WAIT logic. No `vld` until a full subsequent pulse completes.
- Glitches shorter than FILT_LEN samples are invisible to the measurement.

Decomposition:
- Package `servo_pkg`:
  - Error code localparams: ERR_NONE, ERR_SHORT, ERR_LONG, ERR_TMO.
  - Tick constants: 1 ms = 12000, 20 ms frame = 20'h3a980.
  - Default MIN/MAX/TIMEOUT values.
  - `servo_drv` should migrate its frame constant here.
- One sub-module `servo_in_filt`: synchronizer plus run-length filter, outputs `lvl`, rise, fall. It is reusable for other pin inputs.
- FSM, width counter and timeout stay in `servo_cap`.

Test Plan:
- Clean 1.5 ms pulse (18000 ticks high, 20 ms frame) -> `on_t`=18000, `vld` once per frame, at latency SYNC_STAGES+FILT_LEN+1 after the fall; `sig_ok`=1 after the first pulse.
- 4000-tick pulse -> `err`=1 with code 01, `on_t` keeps 18000. A 30000-tick pulse is accepted; a 30001-tick pulse -> `err` code 10 exactly at tick 30001, then no `vld` at its fall.
- 2-cycle glitches (with FILT_LEN=3) injected mid-high and mid-low of a 12000-tick pulse -> `on_t`=12000, no `err`.
- Hold `srv_i` low for 480000+ cycles after valid pulses -> a single `err` code 11, `sig_ok`=0. The next 24000-tick pulse restores `sig_ok`=1 and `on_t`=24000.
- Assert `rst_n` low for 5 cycles during a high pulse -> all outputs return to reset values; the remainder of that pulse produces no `vld`/`err`; the following pulse is measured correctly.
- Loopback from `servo_drv` with `on_t` in {6000, 12000, 24000} -> captured `on_t` equals the driven value every frame.
